// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Load/store master placed directly in front of the byte-addressed,
// big-endian RAM (mv/moc handshake, typeData sizing). It takes one request
// at a time from the CPU datapath, runs one RAM handshake, sign- or
// zero-extends load data and returns a one-cycle done pulse. An illegal size
// or a handshake timeout aborts the access with fault = 1.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   - misaligned halfword/word requests abort with fault, no RAM cycle
//   undefined - addresses pass through unchecked
//
// Parameters:
//   TIMEOUT  maximum WAIT residency before a fault (2..255)
//   ADDR_W   address bus width
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req                request strobe, sampled only in IDLE
//   rd, size, sext     1 = load / size 00 byte 01 half 10 word 11 illegal /
//                      sign-extend enable for loads
//   addr, wdata        byte address, right-justified store data
//   busy, done, fault  handshake towards the CPU (fault valid with done)
//   rdata              extended load data, held until the next accepted req
//   mem_addr, mem_din, mem_dout, mem_rw, mem_mv, mem_moc, mem_type
//                      RAM interface (address, DataIn, DataOut, rw, mv, moc,
//                      typeData)
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              rd,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic              mem_rw,
  output logic              mem_mv,
  input  logic              mem_moc,
  output logic [1:0]        mem_type
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // The last WAIT cycle is the one whose increment would bring the counter
  // to TIMEOUT-1, so a stuck RAM spends TIMEOUT-1 cycles in WAIT.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 2);

  state_t              state_r;
  logic                rd_r;
  logic [1:0]          size_r;
  logic                sext_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [31:0]         wdata_r;
  logic [31:0]         dout_r;
  logic [7:0]          cnt_r;
  logic                pend_fault_r;
  logic                misalign_s;
  logic                reject_s;

  // Right-justify store data for the RAM DataIn port.
  function automatic logic [31:0] fmt_store(input logic [31:0] d, input logic [1:0] sz);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {24'd0, d[7:0]};
      2'b01:   r = {16'd0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Sign- or zero-extend right-justified load data.
  function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [1:0] sz,
                                              input logic s);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {{24{s & d[7]}}, d[7:0]};
      2'b01:   r = {{16{s & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Alignment screen on the incoming request (only active with the feature).
  always_comb begin
    misalign_s = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    case (size)
      2'b01:   misalign_s = addr[0];
      2'b10:   misalign_s = (addr[1:0] != 2'b00);
      default: misalign_s = 1'b0;
    endcase
`else
    misalign_s = 1'b0;
`endif
  end

  // Requests that finish without any RAM cycle.
  always_comb begin
    if (size == 2'b11) begin
      reject_s = 1'b1;
    end else begin
      reject_s = misalign_s;
    end
  end

  // Request sequencer: IDLE -> ISSUE -> WAIT -> FINISH, all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      rd_r         <= 1'b0;
      size_r       <= 2'b00;
      sext_r       <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= 32'd0;
      dout_r       <= 32'd0;
      cnt_r        <= 8'd0;
      pend_fault_r <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      rdata        <= 32'd0;
      mem_addr     <= '0;
      mem_din      <= 32'd0;
      mem_rw       <= 1'b0;
      mem_mv       <= 1'b0;
      mem_type     <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // A req coinciding with the done pulse belongs to the old access
          // window and is dropped.
          if (req && !done) begin
            rd_r    <= rd;
            size_r  <= size;
            sext_r  <= sext;
            addr_r  <= addr;
            wdata_r <= wdata;
            busy    <= 1'b1;
            if (reject_s) begin
              pend_fault_r <= 1'b1;
              state_r      <= ST_FINISH;
            end else begin
              pend_fault_r <= 1'b0;
              state_r      <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          // Address, type and direction launch together with mv.
          mem_addr <= addr_r;
          mem_type <= size_r;
          mem_rw   <= rd_r;
          mem_din  <= fmt_store(wdata_r, size_r);
          mem_mv   <= 1'b1;
          cnt_r    <= 8'd0;
          state_r  <= ST_WAIT;
        end
        ST_WAIT: begin
          // moc is checked before the timeout so a late answer still wins.
          if (mem_moc) begin
            dout_r       <= mem_dout;
            mem_mv       <= 1'b0;
            pend_fault_r <= 1'b0;
            state_r      <= ST_FINISH;
          end else if (cnt_r == LAST_CNT) begin
            mem_mv       <= 1'b0;
            pend_fault_r <= 1'b1;
            state_r      <= ST_FINISH;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          fault <= pend_fault_r;
          if (!pend_fault_r && rd_r) begin
            rdata <= extend_load(dout_r, size_r, sext_r);
          end
          state_r <= ST_IDLE;
        end
        default: begin
          mem_mv  <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Self-checking bench for mem_access_ctrl. A behavioural big-endian RAM with
// a programmable moc delay answers the handshake; a separate reference model
// (byte array plus arithmetic) predicts rdata, fault, latency and mv
// residency for every access. Directed cases cover the documented scenarios,
// followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int TMO   = 16;
  localparam int NEVER = 1000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   = 1'b0;
  logic        rd    = 1'b0;
  logic [1:0]  size  = 2'b00;
  logic        sext  = 1'b0;
  logic [31:0] addr  = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout = 32'd0;
  logic        mem_rw;
  logic        mem_mv;
  logic        mem_moc  = 1'b1;
  logic [1:0]  mem_type;

  int          n_checks = 0;
  int          n_bad    = 0;

  // RAM model state
  logic [7:0]  ram [256];
  int          ram_delay = 1;
  int          ram_wc    = 0;
  int          ram_nb;
  logic [31:0] ram_v;

  // Reference model state
  int          exp_mem [256];
  logic [31:0] exp_rdata = 32'd0;

  mem_access_ctrl #(.TIMEOUT(TMO), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .rd       (rd),
    .size     (size),
    .sext     (sext),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .fault    (fault),
    .rdata    (rdata),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .mem_rw   (mem_rw),
    .mem_mv   (mem_mv),
    .mem_moc  (mem_moc),
    .mem_type (mem_type)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: moc held high while idle, dropped during an access and
  // raised on the ram_delay-th cycle of mv, when the access takes effect.
  always @(negedge clk) begin
    if (!mem_mv) begin
      ram_wc   = 0;
      mem_moc  = 1'b1;
      mem_dout = $urandom;
    end else begin
      ram_wc = ram_wc + 1;
      if (ram_wc == ram_delay) begin
        mem_moc = 1'b1;
        ram_nb  = (mem_type == 2'b11) ? 4 : (1 << mem_type);
        if (mem_rw) begin
          ram_v = 32'd0;
          for (int i = 0; i < ram_nb; i++) begin
            ram_v = {ram_v[23:0], ram[8'(mem_addr + 32'(i))]};
          end
          mem_dout = ram_v;
        end else begin
          for (int i = 0; i < ram_nb; i++) begin
            ram_v = mem_din >> (8 * (ram_nb - 1 - i));
            ram[8'(mem_addr + 32'(i))] = ram_v[7:0];
          end
          mem_dout = $urandom;
        end
      end else if (ram_wc < ram_delay) begin
        mem_moc  = 1'b0;
        mem_dout = $urandom;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full access: predict, drive, watch the handshake, compare.
  task automatic run_txn(input logic t_rd, input logic [1:0] t_size, input logic t_sext,
                         input logic [31:0] t_addr, input logic [31:0] t_wdata,
                         input int t_delay, input logic t_junk);
    int          nb;
    int          w;
    int          lat_exp;
    int          mv_exp;
    int          lat;
    int          mv_cnt;
    logic        f_exp;
    logic        no_ram;
    longint      v;
    logic [31:0] rd_exp;
    logic [31:0] din_exp;

    nb     = (t_size == 2'b11) ? 4 : (1 << t_size);
    no_ram = (t_size == 2'b11);
`ifdef MEM_ALIGN_CHECK_EN
    if (t_size == 2'b01 && t_addr[0]) no_ram = 1'b1;
    if (t_size == 2'b10 && t_addr[1:0] != 2'b00) no_ram = 1'b1;
`endif
    if (no_ram) begin
      f_exp   = 1'b1;
      lat_exp = 2;
      mv_exp  = 0;
    end else begin
      w       = (t_delay < TMO - 1) ? t_delay : TMO - 1;
      f_exp   = (t_delay > TMO - 1);
      lat_exp = w + 3;
      mv_exp  = w;
    end

    din_exp = (nb == 4) ? t_wdata : 32'(longint'(t_wdata) % (longint'(1) << (8 * nb)));
    rd_exp  = exp_rdata;
    if (!f_exp) begin
      if (t_rd) begin
        v = 0;
        for (int i = 0; i < nb; i++) v = v * 256 + exp_mem[8'(t_addr + 32'(i))];
        if (t_sext && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
        rd_exp = 32'(v);
      end else begin
        for (int i = 0; i < nb; i++) exp_mem[8'(t_addr + 32'(i))] = int'((t_wdata >> (8 * (nb - 1 - i))) & 32'hFF);
      end
    end

    ram_delay = t_delay;
    @(posedge clk); #1;
    req = 1'b1; rd = t_rd; size = t_size; sext = t_sext; addr = t_addr; wdata = t_wdata;
    lat = 0;
    mv_cnt = 0;
    while (lat < lat_exp + 8) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        check_eq("busy_after_accept", 32'(busy), 32'd1);
        req = t_junk;
        if (t_junk) begin
          rd = 1'($urandom); size = 2'($urandom); sext = 1'($urandom);
          addr = $urandom; wdata = $urandom;
        end
      end
      if (mem_mv) begin
        mv_cnt++;
        check_eq("mv_addr", mem_addr, t_addr);
        check_eq("mv_type", 32'(mem_type), 32'(t_size));
        check_eq("mv_rw", 32'(mem_rw), 32'(t_rd));
        if (!t_rd) check_eq("mv_din", mem_din, din_exp);
      end
      if (done) break;
    end
    check_eq("latency", 32'(lat), 32'(lat_exp));
    check_eq("done", 32'(done), 32'd1);
    check_eq("fault", 32'(fault), 32'(f_exp));
    check_eq("rdata", rdata, rd_exp);
    check_eq("busy_at_done", 32'(busy), 32'd0);
    check_eq("mv_cycles", 32'(mv_cnt), 32'(mv_exp));
    exp_rdata = rd_exp;
    // req may still be high in the done cycle; it must not start an access.
    @(posedge clk); #1;
    req = 1'b0;
    check_eq("done_one_cycle", 32'(done), 32'd0);
    check_eq("req_on_done_ignored", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'($urandom);
      exp_mem[i] = int'(ram[i]);
    end

    // Reset values
    #12;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_mv", 32'(mem_mv), 32'd0);
    check_eq("rst_rw", 32'(mem_rw), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_addr", mem_addr, 32'd0);
    check_eq("rst_din", mem_din, 32'd0);
    check_eq("rst_type", 32'(mem_type), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed scenarios
    run_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1, 1'b0);
    run_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 1, 1'b0);
    check_eq("word_load_value", rdata, 32'hDEADBEEF);
    run_txn(1'b0, 2'b00, 1'b0, 32'h20, 32'h12345680, 2, 1'b1);
    run_txn(1'b1, 2'b00, 1'b1, 32'h20, 32'h0, 1, 1'b0);
    check_eq("byte_sext", rdata, 32'hFFFFFF80);
    run_txn(1'b1, 2'b00, 1'b0, 32'h20, 32'h0, 3, 1'b0);
    check_eq("byte_zext", rdata, 32'h00000080);
    run_txn(1'b0, 2'b01, 1'b0, 32'h30, 32'hCAFE8001, 1, 1'b0);
    run_txn(1'b1, 2'b01, 1'b1, 32'h30, 32'h0, 2, 1'b1);
    check_eq("half_sext", rdata, 32'hFFFF8001);
    run_txn(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, NEVER, 1'b0);
    run_txn(1'b1, 2'b10, 1'b1, 32'h44, 32'h0, TMO - 1, 1'b0);
    run_txn(1'b0, 2'b10, 1'b0, 32'h48, 32'h55AA55AA, TMO, 1'b0);
    run_txn(1'b1, 2'b11, 1'b0, 32'h50, 32'h0, 1, 1'b1);
    run_txn(1'b1, 2'b10, 1'b0, 32'h13, 32'h0, 1, 1'b0);

    // Reset in the middle of WAIT
    ram_delay = NEVER;
    @(posedge clk); #1;
    req = 1'b1; rd = 1'b1; size = 2'b10; addr = 32'h60;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("mid_wait_mv", 32'(mem_mv), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_mv", 32'(mem_mv), 32'd0);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    exp_rdata = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("rst_no_done", 32'(done), 32'd0);
    end

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      run_txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(TMO - 2, TMO + 2))
                                          : int'($urandom_range(1, 4)),
              1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store master that sits directly upstream of the byte-addressed RAM (mv/moc handshake, big-endian, typeData sizing).
- Accepts one request at a time from the CPU datapath, drives the RAM handshake, and waits for moc.
- Sign- or zero-extends load data and returns a one-cycle done pulse.
- Flags faults on an illegal size or a handshake timeout.

Parameters:
- TIMEOUT, 16: maximum cycles spent in WAIT before a fault is raised; range 2..255.
- ADDR_W, 32: width of the address bus.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  request strobe; sampled only in IDLE
- rd  in  1  1 = load, 0 = store
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- sext  in  1  1 = sign-extend load data, 0 = zero-extend
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, right-justified
- busy  out  1  high from the cycle after req is accepted until done
- done  out  1  one-cycle completion pulse
- fault  out  1  valid only with done; 1 = access aborted
- rdata  out  32  extended load data; valid with done, held until the next accepted req
- mem_addr  out  ADDR_W  connects to RAM address
- mem_din  out  32  connects to RAM DataIn
- mem_dout  in  32  connects to RAM DataOut
- mem_rw  out  1  connects to RAM rw (1 = read)
- mem_mv  out  1  connects to RAM mv
- mem_moc  in  1  connects to RAM moc
- mem_type  out  2  connects to RAM typeData

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low. Reset is not synchronised internally.
- Reset values: state = IDLE; busy, done, fault, mem_mv, mem_rw = 0; rdata, mem_addr, mem_din = 0; mem_type = 00; timeout counter = 0.
- FSM states: IDLE, ISSUE, WAIT, FINISH.
- IDLE:
  - On req = 1, register rd, size, sext, addr and wdata; assert busy.
  - If size = 11, go to FINISH with fault = 1 and issue no RAM cycle.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - Drive mem_addr, mem_type = size and mem_rw = rd.
  - mem_din: byte = {24'b0, wdata[7:0]}; half = {16'b0, wdata[15:0]}; word = wdata.
  - Assert mem_mv = 1; clear the counter; go to WAIT.
  - Address, type and rw are stable no later than mv rises and stay stable until mv falls.
- WAIT:
  - Keep mem_mv = 1 and increment the counter each cycle.
  - When mem_moc = 1 is sampled in the first WAIT cycle or later:
    - capture mem_dout;
    - drop mem_mv;
    - go to FINISH with fault = 0.
  - A moc level present in the ISSUE cycle itself is ignored, because the RAM holds moc high between accesses.
  - When the counter reaches TIMEOUT-1 without moc: drop mem_mv, go to FINISH with fault = 1, leave rdata unchanged.
  - If moc arrives on the same cycle the counter reaches TIMEOUT-1, moc wins and there is no fault.
- FINISH (1 cycle):
  - done = 1 and busy = 0 on the next edge; return to IDLE.
  - On a successful load, rdata is set as follows:
    - byte: {{24{s & mem_dout[7]}}, mem_dout[7:0]}
    - half: {{16{s & mem_dout[15]}}, mem_dout[15:0]}
    - word: mem_dout unchanged
    - where s = latched sext.
  - Stores leave rdata unchanged.
- Request rules:
  - req while busy is ignored; it is neither queued nor errored.
  - req in the same cycle as done is ignored. The earliest new acceptance is the cycle after done.
- Throughput and latency: minimum latency from req to done is 4 cycles (IDLE, ISSUE, WAIT, FINISH) when moc is sampled in the first WAIT cycle.
- Reset mid-operation: mem_mv drops immediately and the FSM returns to IDLE. No done is produced and the partial request is lost.
- Address wrap: there is no wrap logic; the RAM handles addr+1..+3 itself.

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined:
  - Misaligned halfword (addr[0] = 1) and misaligned word (addr[1:0] != 00) go IDLE -> FINISH with fault = 1.
  - No mv is asserted; rdata is unchanged.
- Undefined: addresses pass through unchecked; misaligned accesses proceed normally.

Test Plan:
- Word store at addr 0x10, wdata 0xDEADBEEF, then word load at 0x10 against the RAM model -> rdata = 0xDEADBEEF, fault = 0, done 4 cycles after each req.
- Byte store 0x80 at 0x20, then byte load at 0x20 with sext = 1 -> rdata = 0xFFFFFF80; repeat with sext = 0 -> rdata = 0x00000080.
- Halfword store 0x8001 at 0x30, then half load with sext = 1 -> rdata = 0xFFFF8001; mem_type = 01 throughout the access.
- mem_moc forced low, TIMEOUT = 16 -> mem_mv falls; done = 1 and fault = 1 at TIMEOUT+2 cycles after req; rdata unchanged.
- size = 11 -> done and fault with no mem_mv pulse. Separately, assert rst_n = 0 mid-WAIT -> mem_mv and busy are 0 immediately and done never pulses.
- With MEM_ALIGN_CHECK_EN defined: word load at 0x13 -> fault = 1 with no mv. Without the macro: the same access completes with fault = 0.
